// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer for the instruction-memory address path
//
// Generates instruction fetch addresses in two modes:
//   - single-step: one advance per rising edge of i_step while IDLE
//   - free-run: one advance per clock while RUN
// Also supports absolute loads, signed relative branches, halt requests and
// an address limit.
//
// Limit behaviour is selected by the PC_HALT_ON_LIMIT_EN macro:
//   defined   : a limit event freezes the PC and enters HALT (o_wrap stays low)
//   undefined : a limit event wraps the PC to 0 and pulses o_wrap
//
// Parameters:
//   PC_CANT_BITS  address width N
//   SUM_DIR       increment per normal advance (unsigned, < 2^N)
//   PC_LIMIT      last valid address (<= 2^N-1)
//
// Ports:
//   i_clock       clock
//   i_reset       synchronous reset, active low
//   i_step        step request; each rising edge advances once while IDLE
//   i_run         level, requests free-run
//   i_halt        level, requests halt
//   i_load        absolute load strobe
//   i_load_addr   load target
//   i_branch      qualifies the current advance as a relative branch
//   i_offset      two's-complement branch offset
//   o_addr        current PC (registered)
//   o_state       00 IDLE, 01 RUN, 10 HALT
//   o_halted      high while in HALT
//   o_wrap        one-cycle pulse when o_addr first shows a wrapped value

module pc_sequencer #(
  parameter int PC_CANT_BITS = 11,
  parameter int SUM_DIR      = 1,
  parameter int PC_LIMIT     = (1 << PC_CANT_BITS) - 1
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_step,
  input  logic                    i_run,
  input  logic                    i_halt,
  input  logic                    i_load,
  input  logic [PC_CANT_BITS-1:0] i_load_addr,
  input  logic                    i_branch,
  input  logic [PC_CANT_BITS-1:0] i_offset,
  output logic [PC_CANT_BITS-1:0] o_addr,
  output logic [1:0]              o_state,
  output logic                    o_halted,
  output logic                    o_wrap
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  // One extra bit so an increment past the top of the address space is
  // still seen as exceeding the limit instead of silently wrapping.
  localparam logic [PC_CANT_BITS:0] SUM_EXT   = (PC_CANT_BITS+1)'(SUM_DIR);
  localparam logic [PC_CANT_BITS:0] LIMIT_EXT = (PC_CANT_BITS+1)'(PC_LIMIT);

  state_t                  state_q;
  state_t                  state_d;
  logic [PC_CANT_BITS-1:0] pc_q;
  logic [PC_CANT_BITS-1:0] pc_d;
  logic                    wrap_q;
  logic                    wrap_d;
  logic                    step_d;

  logic                    step_edge;
  logic                    advance;
  logic [PC_CANT_BITS:0]   sum;
  logic [PC_CANT_BITS-1:0] target;
  logic [PC_CANT_BITS-1:0] next_pc;
  logic                    limit_hit;

  // step_d clears on reset, so a step held through reset still yields one edge.
  assign step_edge = i_step & ~step_d;

  assign sum    = {1'b0, pc_q} + SUM_EXT;
  assign target = pc_q + i_offset;

  // Candidate address for an advance and whether it crosses the limit.
  always_comb begin
    next_pc   = sum[PC_CANT_BITS-1:0];
    limit_hit = (sum > LIMIT_EXT);
    if (i_branch) begin
      next_pc   = target;
      limit_hit = ({1'b0, target} > LIMIT_EXT);
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      wrap_q  <= 1'b0;
      step_d  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wrap_q  <= wrap_d;
      step_d  <= i_step;
    end
  end

  // Priority per cycle: load, then halt, then advance. Advance is decided on
  // the current state, so the first RUN increment lands one cycle after the
  // IDLE->RUN transition.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wrap_d  = 1'b0;
    advance = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_load) begin
          pc_d = i_load_addr;
        end else if (i_halt) begin
          state_d = ST_HALT;
        end else begin
          advance = step_edge;
          if (i_run) begin
            state_d = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (i_load) begin
          pc_d = i_load_addr;
        end else if (i_halt) begin
          state_d = ST_HALT;
        end else begin
          advance = 1'b1;
          if (!i_run) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_HALT: begin
        // Only a load releases HALT; step, run and branch are ignored here.
        if (i_load) begin
          pc_d    = i_load_addr;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (advance) begin
      if (!limit_hit) begin
        pc_d = next_pc;
      end else begin
`ifdef PC_HALT_ON_LIMIT_EN
        // Leave the PC on the last address reached and stop.
        state_d = ST_HALT;
`else
        pc_d   = '0;
        wrap_d = 1'b1;
`endif
      end
    end
  end

  assign o_addr   = pc_q;
  assign o_state  = state_q;
  assign o_halted = (state_q == ST_HALT);
  assign o_wrap   = wrap_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the instruction-memory address path of the debug/run datapath. It generates instruction fetch addresses in single-step mode (one advance per rising edge of a step request) or in free-run mode (one advance per clock). It also supports absolute loads, signed relative branches, a halt request and an address limit with wrap or halt behaviour. Its output `o_addr` drives the program-memory address port directly.

## Interface
- `PC_CANT_BITS`, default 11: address width N.
- `SUM_DIR`, default 1: increment added per normal advance; unsigned, must be less than 2^N.
- `PC_LIMIT`, default 2^PC_CANT_BITS-1: last valid address; must be ≤ 2^N-1.

- `i_clock`, in, 1: clock.
- `i_reset`, in, 1: reset, synchronous, active-low.
- `i_step`, in, 1: step request; each rising edge advances once while in IDLE.
- `i_run`, in, 1: level; 1 requests free-run.
- `i_halt`, in, 1: level; 1 requests halt.
- `i_load`, in, 1: absolute load strobe.
- `i_load_addr`, in, N: load target.
- `i_branch`, in, 1: qualifies the current advance as a relative branch.
- `i_offset`, in, N: two's-complement branch offset.
- `o_addr`, out, N: current PC, registered.
- `o_state`, out, 2: 00 IDLE, 01 RUN, 10 HALT.
- `o_halted`, out, 1: equals (`o_state` == HALT).
- `o_wrap`, out, 1: one-cycle pulse, registered.

## Operation
- Step edge detection:
  - `step_edge = i_step & ~step_d`, where `step_d` is a registered copy of `i_step`.
  - `step_d` resets to 0, so `i_step` held high through reset produces one edge on the first active cycle.
- State transitions, evaluated on the current state:
  - IDLE → HALT if `i_halt`; otherwise → RUN if `i_run`.
  - RUN → HALT if `i_halt`; otherwise → IDLE if `~i_run`.
  - HALT → IDLE only on `i_load`; all other inputs are ignored.
- `advance = (state==RUN) | (state==IDLE & step_edge)`. It is gated off when `i_halt` or `i_load` is asserted in the same cycle.
- Per-cycle priority is `i_load` > `i_halt` > advance.
  - `i_load` in IDLE or RUN: PC <= `i_load_addr` and state is unchanged.
  - `i_load` in HALT: PC <= `i_load_addr` and state → IDLE.
- Advance computation:
  - Increment: `sum = {1'b0,PC} + SUM_DIR`, computed in N+1 bits. A limit event occurs when `sum > PC_LIMIT`.
  - Branch (`i_branch`=1 during advance): `target = PC + i_offset`, modulo 2^N. A limit event occurs when `target > PC_LIMIT`.
  - No limit event: PC <= `sum[N-1:0]` or `target`.
  - `i_branch` outside an advance cycle is ignored.
- Limit event behaviour is set by the configuration macro (see Configuration).
- `i_load_addr` > `PC_LIMIT` is accepted as-is. The next advance evaluates the limit normally.

## Timing
- Reset values:
  - `o_addr`=0, `o_state`=IDLE, `o_halted`=0, `o_wrap`=0, `step_d`=0.
- Reset takes priority over all inputs and aborts any mode, including RUN and HALT.
- Latency:
  - `o_addr` updates on the clock edge that samples a qualifying condition, i.e. the cycle after the `i_step` rise is presented.
  - A load is visible one cycle after `i_load`.
- RUN advances on every clock, including the edge that moves IDLE→RUN? No. The advance is based on the current state, so the first RUN increment occurs one cycle after the transition.
- `o_wrap` is high for exactly the one cycle in which `o_addr` first shows the wrapped value. It is low otherwise.
- `i_step` held high gives exactly one advance. A new advance requires a low cycle first.

## Configuration
- `PC_HALT_ON_LIMIT_EN` defined:
  - A limit event leaves PC unchanged and moves the state to HALT.
  - `o_wrap` is never asserted.
- `PC_HALT_ON_LIMIT_EN` undefined:
  - A limit event sets PC <= 0 and pulses `o_wrap`.
  - The state is unchanged.

## Test plan
All scenarios use PC_CANT_BITS=4, SUM_DIR=1, PC_LIMIT=11.
- Reset, then 3 `i_step` pulses (high 2 cycles, low 2 cycles) → `o_addr` steps 0→1→2→3, each one cycle after the rise; `o_state`=00 throughout.
- `i_step` held high for 10 cycles → exactly one increment.
- `i_run`=1 for 5 cycles from PC=2 → `o_state`=01 after 1 cycle, then PC 3,4,5,6. Drop `i_run` → state returns to IDLE and PC freezes.
- From PC=5, step with `i_branch`=1, `i_offset`=4'b1110 (−2) → PC=3, `o_wrap`=0.
- Run from PC=10, macro undefined → PC 11, then 0 with `o_wrap`=1 for one cycle. Macro defined → PC stays at 11, `o_state`=10, `o_halted`=1.
- In HALT, pulse `i_step` and `i_run` → PC and state unchanged. Then `i_load`=1 with `i_load_addr`=7 → PC=7, state IDLE. `i_load` and `i_halt` together in RUN → PC=`i_load_addr`, state stays RUN.
